boot_image_loader: RTL and testbench
====================================

Name: boot_image_loader

Overview:
Parametrised loader/run controller that replaces hand-sequenced instr/ins_we and data/data_we pokes into processor_top. It accepts a framed word stream over a valid/ready handshake and writes segments into NUM_CH memory channels (ch0 = instruction memory, ch1 = data memory, further channels spare). It then releases the processor from reset and supervises execution until done or timeout, reporting the cycle count and status. It sits between the stimulus source (bench or UART front end) and processor_top.

Parameters:
ADDR_W, 10, memory word-address width per channel
DATA_W, 32, stream and memory word width
NUM_CH, 2, number of memory channels (1..4)
CH_W, 2, channel-select field width in the header
MAX_CYCLES, 1024, run-phase timeout in clk cycles (must be >= 1)
CNT_W, 16, width of cycle_count

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
restart  in  1  synchronous pulse; abort and return to header wait
s_valid  in  1  stream word valid
s_ready  out  1  loader can accept a word
s_data  in  DATA_W  stream word (header, payload or checksum)
mem_we  out  NUM_CH  one-hot write enable, one bit per channel
mem_addr  out  ADDR_W  write address, shared by all channels
mem_wdata  out  DATA_W  write data, shared by all channels
cpu_rst  out  1  active-high reset to processor_top
cpu_done  in  1  processor done flag
busy  out  1  loading or running
run_ok  out  1  run ended with cpu_done
timeout  out  1  run ended by MAX_CYCLES
err  out  1  framing or checksum error
cycle_count  out  CNT_W  cycles spent in RUN, saturating

Behaviour:
- Reset (rst=0, async): state HDR; mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, s_ready=0, busy=0, run_ok=0, timeout=0, err=0, cycle_count=0. s_ready rises on the first clk edge after reset release.
- Header word fields: base=s_data[ADDR_W-1:0]; count=s_data[2*ADDR_W-1:ADDR_W]; ch=s_data[2*ADDR_W+:CH_W]. Elaboration-time error if 2*ADDR_W+CH_W > DATA_W.
- HDR: s_ready=1. On handshake:
  - count!=0 and ch<NUM_CH -> LOAD; latch base, count and ch; busy=1.
  - ch>=NUM_CH -> ERR.
  - count==0 -> RUN (or CSUM if the optional feature is on).
- LOAD: s_ready=1. Each handshake registers one write: mem_we[ch]=1, mem_addr=(base+idx) mod 2^ADDR_W, mem_wdata=s_data, one cycle after the handshake. idx increments. After the count-th word -> HDR. Gaps in s_valid stall without side effects.
- RUN: s_ready=0, cpu_rst=0, busy=1. cycle_count increments each cycle and saturates at 2^CNT_W-1.
  - cpu_done=1 -> DONE with run_ok=1.
  - Otherwise, on reaching MAX_CYCLES -> DONE with timeout=1.
  - If cpu_done and timeout occur in the same cycle, done wins.
- DONE: cpu_rst=1, busy=0, s_ready=0. Flags and cycle_count hold until restart or reset.
- ERR: err=1, cpu_rst=1, s_ready=0, busy=0. Held until restart or reset.
- restart: from any state, next cycle goes to HDR. Clears flags and cycle_count, sets cpu_rst=1 and mem_we=0. s_ready is forced 0 in the restart cycle, so no handshake occurs then. Memory contents already written are not undone.
- cpu_rst stays 1 in every state except RUN.

Optional Feature:
BOOT_LOADER_CSUM_EN.
- Defined: a sum of all payload words mod 2^DATA_W is accumulated. The end header is followed by one checksum word in state CSUM (s_ready=1). Match -> RUN; mismatch -> ERR, and cpu_rst stays asserted.
- Undefined: no CSUM state; the end header goes straight to RUN.

Decomposition:
- Package boot_loader_pkg: state enum (HDR, LOAD, CSUM, RUN, DONE, ERR), header field offset functions, default parameter constants.
- One sub-module, boot_run_timer: cycle counter plus MAX_CYCLES compare and saturation. It is used in RUN and cleared by restart.

Test Plan:
- Load 15 instructions: header ch0/base0/count15, 15 words, end header. Required: mem_we[0] pulses at addresses 0..14 with matching data; cpu_rst falls the cycle after the end handshake.
- Load a data segment: header ch1/base100/count1, word 42. Required: mem_we[1]=1 at mem_addr=100, mem_wdata=42; mem_we[0] stays 0.
- Address wrap: ch0, base1022, count4, with s_valid gaps. Required: writes at 1022, 1023, 0, 1, exactly four pulses.
- Run supervision:
  - cpu_done asserted 37 cycles into RUN -> run_ok=1, cycle_count=37, cpu_rst=1.
  - MAX_CYCLES=64 with no done -> timeout=1, cycle_count=64.
  - cpu_done on cycle 64 -> run_ok=1, timeout=0.
- Errors and aborts:
  - Header with ch=3 -> err=1, s_ready=0; a later restart -> HDR, err=0.
  - restart mid-LOAD -> no further writes, s_ready low for one cycle.
  - rst mid-RUN -> all outputs at reset values immediately.
- With BOOT_LOADER_CSUM_EN: payload {1,2,3} with checksum 6 -> RUN; checksum 7 -> err=1 and cpu_rst held.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// Shared types and header-field helpers for the boot image loader.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_LOAD = 3'd1,
    ST_CSUM = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  localparam int unsigned DEF_ADDR_W     = 10;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_NUM_CH     = 2;
  localparam int unsigned DEF_CH_W       = 2;
  localparam int unsigned DEF_MAX_CYCLES = 1024;
  localparam int unsigned DEF_CNT_W      = 16;

  // Header layout, LSB first: base[ADDR_W], count[ADDR_W], ch[CH_W]
  function automatic int unsigned hdr_count_lsb(input int unsigned addr_w);
    return addr_w;
  endfunction

  function automatic int unsigned hdr_ch_lsb(input int unsigned addr_w);
    return 2 * addr_w;
  endfunction

  function automatic int unsigned hdr_width(input int unsigned addr_w, input int unsigned ch_w);
    return 2 * addr_w + ch_w;
  endfunction

endpackage

// File: rtl/boot_run_timer.sv
// Run-phase cycle counter: saturating cycle_count plus MAX_CYCLES expiry flag.
module boot_run_timer #(
  parameter int unsigned MAX_CYCLES = 1024,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_expire
);

  localparam int unsigned RUN_W = $clog2(MAX_CYCLES + 1);

  if (MAX_CYCLES < 1) begin : g_max_chk
    $error("boot_run_timer: MAX_CYCLES must be >= 1");
  end

  logic [RUN_W-1:0] r_run;
  logic [CNT_W-1:0] r_count;

  // Timeout is tracked separately so a narrow CNT_W cannot hide it
  assign o_expire = i_en && (r_run == RUN_W'(MAX_CYCLES - 1));
  assign o_count  = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run   <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_run   <= '0;
      r_count <= '0;
    end else if (i_en) begin
      if (r_run != RUN_W'(MAX_CYCLES)) r_run <= r_run + 1'b1;
      if (r_count != '1) r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/boot_image_loader.sv
// Framed-stream boot loader and run supervisor sitting in front of processor_top.
// Optional checksum word after the end header: define BOOT_LOADER_CSUM_EN.
module boot_image_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned CH_W       = DEF_CH_W,
  parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic [NUM_CH-1:0] mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  input  logic              cpu_done,
  output logic              busy,
  output logic              run_ok,
  output logic              timeout,
  output logic              err,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int unsigned CNT_LSB = hdr_count_lsb(ADDR_W);
  localparam int unsigned CH_LSB  = hdr_ch_lsb(ADDR_W);

  if (hdr_width(ADDR_W, CH_W) > DATA_W) begin : g_hdr_chk
    $error("boot_image_loader: header fields do not fit in DATA_W");
  end
  if (NUM_CH < 1 || NUM_CH > 4) begin : g_ch_chk
    $error("boot_image_loader: NUM_CH must be 1..4");
  end

`ifdef BOOT_LOADER_CSUM_EN
  localparam state_e END_ST = ST_CSUM;
`else
  localparam state_e END_ST = ST_RUN;
`endif

  state_e            r_state, w_next;
  logic              r_rdy_en, r_busy, r_run_ok, r_timeout;
  logic [ADDR_W-1:0] r_base, r_count, r_idx;
  logic [CH_W-1:0]   r_ch;
  logic [NUM_CH-1:0] r_we, w_ch_sel;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] w_hdr_base, w_hdr_count;
  logic [CH_W-1:0]   w_hdr_ch;
  logic              w_hdr_ch_ok, w_accept, w_hs, w_last, w_run, w_expire;
  logic              w_cpu_rst, w_err, w_busy;

  assign w_hdr_base  = s_data[ADDR_W-1:0];
  assign w_hdr_count = s_data[CNT_LSB +: ADDR_W];
  assign w_hdr_ch    = s_data[CH_LSB +: CH_W];
  assign w_hdr_ch_ok = 32'(w_hdr_ch) < NUM_CH;

  // r_rdy_en keeps s_ready low until the first edge after reset release
  assign w_accept = (r_state == ST_HDR && r_rdy_en) || r_state == ST_LOAD || r_state == ST_CSUM;
  assign s_ready  = w_accept && !restart;
  assign w_hs     = s_valid && s_ready;
  assign w_last   = (r_idx == r_count - 1'b1);
  assign w_run    = (r_state == ST_RUN);

  always_comb begin
    w_ch_sel = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) w_ch_sel[c] = (32'(r_ch) == c);
  end

`ifdef BOOT_LOADER_CSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic              w_sum_ok;

  assign w_sum_ok = (s_data == r_sum);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             r_sum <= '0;
    else if (restart)                     r_sum <= '0;
    else if (r_state == ST_LOAD && w_hs)  r_sum <= r_sum + s_data;
  end
`endif

  boot_run_timer #(
    .MAX_CYCLES (MAX_CYCLES),
    .CNT_W      (CNT_W)
  ) u_timer (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_clr    (restart),
    .i_en     (w_run),
    .o_count  (cycle_count),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_HDR;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_cpu_rst = 1'b1;
    w_err     = 1'b0;
    w_busy    = 1'b0;
    case (r_state)
      ST_HDR: begin
        w_busy = r_busy;
        if (w_hs) begin
          if (!w_hdr_ch_ok)            w_next = ST_ERR;
          else if (w_hdr_count != '0)  w_next = ST_LOAD;
          else                         w_next = END_ST;
        end
      end
      ST_LOAD: begin
        w_busy = 1'b1;
        if (w_hs && w_last) w_next = ST_HDR;
      end
`ifdef BOOT_LOADER_CSUM_EN
      ST_CSUM: begin
        w_busy = 1'b1;
        if (w_hs) w_next = w_sum_ok ? ST_RUN : ST_ERR;
      end
`endif
      ST_RUN: begin
        w_busy    = 1'b1;
        w_cpu_rst = 1'b0;
        if (cpu_done || w_expire) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_DONE;
      ST_ERR:  w_err  = 1'b1;
      default: w_next = ST_HDR;
    endcase
    if (restart) w_next = ST_HDR;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdy_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_run_ok  <= 1'b0;
      r_timeout <= 1'b0;
      r_base    <= '0;
      r_count   <= '0;
      r_idx     <= '0;
      r_ch      <= '0;
      r_we      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      r_we     <= '0;
      if (restart) begin
        r_busy    <= 1'b0;
        r_run_ok  <= 1'b0;
        r_timeout <= 1'b0;
      end else begin
        if (r_state == ST_HDR && w_hs && w_hdr_ch_ok && w_hdr_count != '0) begin
          r_base  <= w_hdr_base;
          r_count <= w_hdr_count;
          r_ch    <= w_hdr_ch;
          r_idx   <= '0;
          r_busy  <= 1'b1;
        end
        if (r_state == ST_LOAD && w_hs) begin
          r_we    <= w_ch_sel;
          r_addr  <= r_base + r_idx;
          r_wdata <= s_data;
          r_idx   <= r_idx + 1'b1;
        end
        // done wins over a coincident timeout
        if (w_run && cpu_done)      r_run_ok  <= 1'b1;
        else if (w_run && w_expire) r_timeout <= 1'b1;
      end
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cpu_rst   = w_cpu_rst;
  assign busy      = w_busy;
  assign err       = w_err;
  assign run_ok    = r_run_ok;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_boot_image_loader.sv
// Directed/randomized bench for boot_image_loader against a queue-based write model.
// Define BOOT_LOADER_CSUM_EN to also exercise the checksum word.
module tb_boot_image_loader;

  localparam int MAXC = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        restart = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        cpu_done = 1'b0;

  logic        s_ready, cpu_rst, busy, run_ok, timeout, err;
  logic [1:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [15:0] cycle_count;

  logic        s_ready_b, cpu_rst_b, busy_b, run_ok_b, timeout_b, err_b;
  logic [1:0]  mem_we_b;
  logic [9:0]  mem_addr_b;
  logic [31:0] mem_wdata_b;
  logic [4:0]  cycle_count_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [43:0] obs_q[$];
  logic [43:0] exp_q[$];
`ifdef BOOT_LOADER_CSUM_EN
  logic [31:0] m_sum = '0;
`endif

  boot_image_loader #(.MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst), .restart(restart), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .cpu_done(cpu_done), .busy(busy), .run_ok(run_ok),
    .timeout(timeout), .err(err), .cycle_count(cycle_count)
  );

  boot_image_loader #(.MAX_CYCLES(MAXC), .CNT_W(5)) dut_sat (
    .clk(clk), .rst(rst), .restart(restart), .s_valid(s_valid), .s_ready(s_ready_b),
    .s_data(s_data), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .cpu_rst(cpu_rst_b), .cpu_done(cpu_done), .busy(busy_b), .run_ok(run_ok_b),
    .timeout(timeout_b), .err(err_b), .cycle_count(cycle_count_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we != '0) obs_q.push_back({mem_we, mem_addr, mem_wdata});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input int ch, input int base, input int cnt);
    logic [31:0] h;
    h = '0;
    h[9:0]   = base[9:0];
    h[19:10] = cnt[9:0];
    h[21:20] = ch[1:0];
    return h;
  endfunction

  task automatic send(input logic [31:0] w, input bit gaps);
    int n;
    @(negedge clk);
    if (gaps) begin
      n = $urandom_range(1, 2);
      for (int i = 0; i < n; i++) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
    end
    s_valid = 1'b1;
    s_data  = w;
    #1;
    for (int k = 0; k < 20 && !s_ready; k++) begin
      @(negedge clk);
      #1;
    end
    check("send_rdy", s_ready, 1'b1);
    @(posedge clk);
  endtask

  task automatic load_seg(input int ch, input int base, input int cnt,
                          input logic [31:0] words[$], input bit gaps);
    logic [1:0] we;
    logic [9:0] a;
    we = '0;
    we[ch] = 1'b1;
    send(hdr(ch, base, cnt), gaps);
    #1 check("busy_load", busy, 1'b1);
    foreach (words[i]) begin
      send(words[i], gaps);
      a = 10'((base + i) % 1024);
      exp_q.push_back({we, a, words[i]});
`ifdef BOOT_LOADER_CSUM_EN
      m_sum = m_sum + words[i];
`endif
    end
  endtask

  task automatic end_load();
    send(32'h0, 1'b0);
`ifdef BOOT_LOADER_CSUM_EN
    send(m_sum, 1'b0);
`endif
  endtask

  task automatic run_phase(input int done_cycle, input string tag);
    int  endc;
    bit  ok;
    ok   = (done_cycle >= 1) && (done_cycle <= MAXC);
    endc = ok ? done_cycle : MAXC;
    for (int c = 1; c <= endc + 2; c++) begin
      @(negedge clk);
      s_valid  = 1'b0;
      cpu_done = (c == done_cycle);
      #1;
      if (c == 1) begin
        check({tag, "_cpurst_run"}, cpu_rst, 1'b0);
        check({tag, "_busy_run"}, busy, 1'b1);
        check({tag, "_rdy_run"}, s_ready, 1'b0);
      end
      if (c == endc) check({tag, "_cnt_last"}, cycle_count, 64'(endc - 1));
    end
    cpu_done = 1'b0;
    check({tag, "_run_ok"}, run_ok, ok);
    check({tag, "_timeout"}, timeout, !ok);
    check({tag, "_cnt"}, cycle_count, 64'(endc < 65535 ? endc : 65535));
    check({tag, "_cnt_sat"}, cycle_count_b, 64'(endc < 31 ? endc : 31));
    check({tag, "_cpurst_done"}, cpu_rst, 1'b1);
    check({tag, "_busy_done"}, busy, 1'b0);
    check({tag, "_rdy_done"}, s_ready, 1'b0);
  endtask

  task automatic restart_pulse(input string tag, input bit keep_valid);
    @(negedge clk);
    restart = 1'b1;
    s_valid = keep_valid;
    s_data  = 32'h0000_5a5a;
    #1 check({tag, "_rdy_in_restart"}, s_ready, 1'b0);
    @(negedge clk);
    restart = 1'b0;
    s_valid = 1'b0;
    #1;
    check({tag, "_rdy_after"}, s_ready, 1'b1);
    check({tag, "_flags"}, {err, run_ok, timeout, busy, cpu_rst}, 5'b00001);
    check({tag, "_cnt_clr"}, cycle_count, 0);
    check({tag, "_we_clr"}, mem_we, 0);
`ifdef BOOT_LOADER_CSUM_EN
    m_sum = '0;
`endif
  endtask

  task automatic compare_writes(input string tag);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_nwr"}, obs_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < obs_q.size()) check($sformatf("%s_wr%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_mem"}, {mem_we, mem_addr, mem_wdata}, 0);
    check({tag, "_ctl"}, {cpu_rst, s_ready, busy, run_ok, timeout, err}, 6'b100000);
    check({tag, "_cnt"}, cycle_count, 0);
  endtask

  initial begin
    logic [31:0] q[$];
    int rch, rbase, rcnt;

    repeat (2) @(negedge clk);
    #1 check_reset("rst");
    @(negedge clk);
    rst = 1'b1;
    #1 check("rdy_before_edge", s_ready, 1'b0);
    @(negedge clk);
    #1 check("rdy_after_edge", s_ready, 1'b1);

    q.delete();
    for (int i = 0; i < 15; i++) q.push_back($urandom);
    load_seg(0, 0, 15, q, 1'b0);
    q.delete();
    q.push_back(32'd42);
    load_seg(1, 100, 1, q, 1'b0);
    q.delete();
    for (int i = 0; i < 4; i++) q.push_back($urandom);
    load_seg(0, 1022, 4, q, 1'b1);
    rch   = $urandom_range(0, 1);
    rbase = $urandom_range(0, 1023);
    rcnt  = $urandom_range(1, 6);
    q.delete();
    for (int i = 0; i < rcnt; i++) q.push_back($urandom);
    load_seg(rch, rbase, rcnt, q, 1'b1);
    end_load();
    #1 check("cpu_rst_fall", cpu_rst, 1'b0);
    run_phase(37, "done37");
    compare_writes("load");

    restart_pulse("rs_tmo", 1'b0);
    end_load();
    run_phase(0, "tmo");

    restart_pulse("rs_d64", 1'b0);
    end_load();
    run_phase(MAXC, "done64");

    restart_pulse("rs_rnd", 1'b0);
    end_load();
    run_phase($urandom_range(1, MAXC - 1), "done_rnd");

    restart_pulse("rs_err", 1'b0);
    send(hdr(3, 0, 5), 1'b0);
    @(negedge clk);
    #1;
    check("err_set", err, 1'b1);
    check("err_rdy", s_ready, 1'b0);
    check("err_cpurst", cpu_rst, 1'b1);
    check("err_busy", busy, 1'b0);
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("err_hold", err, 1'b1);
    restart_pulse("rs_clr_err", 1'b0);

    q.delete();
    for (int i = 0; i < 3; i++) q.push_back($urandom);
    load_seg(1, $urandom_range(0, 1023), 6, q, 1'b0);
    restart_pulse("rs_abort", 1'b1);
    compare_writes("abort");
    q.delete();
    q.push_back($urandom);
    load_seg(0, 7, 1, q, 1'b0);
    compare_writes("post_abort");

    end_load();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1 check_reset("rst_run");
    @(negedge clk);
    rst = 1'b1;
    obs_q.delete();
`ifdef BOOT_LOADER_CSUM_EN
    m_sum = '0;
`endif

`ifdef BOOT_LOADER_CSUM_EN
    q.delete();
    q.push_back(32'd1);
    q.push_back(32'd2);
    q.push_back(32'd3);
    load_seg(1, 200, 3, q, 1'b0);
    send(32'h0, 1'b0);
    send(32'd6, 1'b0);
    #1 check("csum_ok_run", cpu_rst, 1'b0);
    run_phase(5, "csum_ok");
    compare_writes("csum_ok");

    restart_pulse("rs_csum", 1'b0);
    load_seg(1, 200, 3, q, 1'b0);
    send(32'h0, 1'b0);
    send(32'd7, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    check("csum_bad_err", err, 1'b1);
    check("csum_bad_cpurst", cpu_rst, 1'b1);
    repeat (3) @(negedge clk);
    #1 check("csum_bad_hold", {err, cpu_rst}, 2'b11);
    compare_writes("csum_bad");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
